// File: rtl/zero_indices_pkg.sv
// Shared width helpers for the zero-index packer; the record type itself is
// built per instance from these so it tracks the enumerator width W.
package zero_indices_pkg;

  function automatic int index_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int count_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Fixed field values of the synthesised record for a batch with no zeros.
  localparam logic EMPTY_REC_LAST  = 1'b1;
  localparam logic EMPTY_REC_EMPTY = 1'b1;

endpackage

// File: rtl/zero_indices_pack_fifo.sv
// Generic DEPTH-entry synchronous FIFO; head entry is read straight from the
// storage registers, so a push becomes visible on the following cycle.
module zero_indices_pack_fifo #(
  parameter int DEPTH = 4,
  parameter type rec_t = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  rec_t wdata,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  rec_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/zero_indices_pack.sv
// Downstream stage of the zero-index enumerator: queues emitted indices,
// tags batch ends with a zero count and synthesises records for empty batches.
module zero_indices_pack
  import zero_indices_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_load,
  input  logic                   in_valid,
  input  logic [$clog2(W)-1:0]   in_index,
  input  logic                   in_last,
  input  logic                   in_done,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(W)-1:0]   out_index,
  output logic                   out_last,
  output logic                   out_empty,
  output logic [$clog2(W+1)-1:0] out_count
);

  localparam int IW = index_w(W);
  localparam int CW = count_w(W);

  typedef logic [IW-1:0] index_t;
  typedef logic [CW-1:0] count_t;

  typedef struct packed {
    index_t index;
    logic   last;
    logic   empty;
    count_t count;
  } rec_t;

  logic   batch_open;
  count_t cnt;
  logic   pend_empty;

  logic   full;
  logic   fifo_empty;
  logic   data_push;
  logic   empty_push;
  logic   done_act;
  logic   pop;
  rec_t   wdata;
  rec_t   head;
  rec_t   head_q;

  assign in_ready   = ~full;
  // A response shown during the load cycle belongs to the old vector.
  assign data_push  = in_valid & ~full & ~in_load;
  assign empty_push = pend_empty & ~full & ~data_push;
  assign done_act   = in_done & batch_open & ~in_load;
  assign pop        = out_valid & out_ready;

  always_comb begin
    wdata = '0;
    if (data_push) begin
      wdata.index = in_index;
      wdata.last  = in_last;
      wdata.empty = 1'b0;
      wdata.count = in_last ? cnt + count_t'(1) : '0;
    end else begin
      wdata.index = '0;
      wdata.last  = EMPTY_REC_LAST;
      wdata.empty = EMPTY_REC_EMPTY;
      wdata.count = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      batch_open <= 1'b0;
      cnt        <= '0;
      pend_empty <= 1'b0;
    end else begin
      if (empty_push) pend_empty <= 1'b0;
      if (data_push) begin
        cnt <= in_last ? '0 : cnt + count_t'(1);
        if (in_last) batch_open <= 1'b0;
      end
      if (done_act) begin
        batch_open <= 1'b0;
        if ((cnt == '0) && !data_push) pend_empty <= 1'b1;
      end
      // A new load restarts counting; any pending empty record still drains.
      if (in_load) begin
        batch_open <= 1'b1;
        cnt        <= '0;
      end
    end
  end

  zero_indices_pack_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_push | empty_push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head_q),
    .full  (full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign head      = out_valid ? head_q : '0;
  assign out_index = head.index;
  assign out_last  = head.last;
  assign out_empty = head.empty;
  assign out_count = head.count;

endmodule

// File: tb/tb_zero_indices_pack.sv
// Directed bench for zero_indices_pack (W=8, DEPTH=4) driving a behavioural
// zero-index enumerator and checking the accepted record stream.
module tb_zero_indices_pack;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_load;
  logic [7:0] load_vec;
  logic       in_valid;
  logic [2:0] in_index;
  logic       in_last;
  logic       in_done;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_index;
  logic       out_last;
  logic       out_empty;
  logic [3:0] out_count;

  logic [7:0] zmask;
  logic [9:0] q[$];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  zero_indices_pack #(.W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_load   (in_load),
    .in_valid  (in_valid),
    .in_index  (in_index),
    .in_last   (in_last),
    .in_done   (in_done),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_empty (out_empty),
    .out_count (out_count)
  );

  // Enumerator model: zmask holds the zero bits still to be reported.
  always_comb begin
    in_valid = |zmask;
    in_done  = ~|zmask;
    in_last  = (|zmask) && ((zmask & (zmask - 8'd1)) == 8'd0);
    in_index = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (zmask[i]) in_index = 3'(i);
  end

  always @(posedge clk) begin
    if (rst)                        zmask <= 8'd0;
    else if (in_load)               zmask <= ~load_vec;
    else if (in_valid && in_ready)  zmask <= zmask & (zmask - 8'd1);
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready)
      q.push_back({out_index, out_last, out_empty, out_count});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rec(input string tag, input int idx, input bit last,
                            input bit emp, input int cnt);
    logic [9:0] got;
    logic [9:0] exp;
    exp = {3'(idx), last, emp, 4'(cnt)};
    got = (q.size() > 0) ? q.pop_front() : 10'h3FF;
    check(tag, {22'd0, got}, {22'd0, exp});
  endtask

  task automatic expect_none(input string tag);
    check(tag, q.size(), 0);
  endtask

  task automatic load(input logic [7:0] vec);
    in_load  = 1'b1;
    load_vec = vec;
    @(negedge clk);
    in_load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_load = 1'b0; load_vec = 8'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Two zeros; trailing done is ignored.
    out_ready = 1'b1;
    load(8'b1111_0101);
    repeat (8) @(negedge clk);
    expect_rec("t1_r0", 1, 0, 0, 0);
    expect_rec("t1_r1", 3, 1, 0, 2);
    expect_none("t1_extra");

    // No zeros: one synthesised empty record despite repeated done.
    load(8'hFF);
    repeat (8) @(negedge clk);
    expect_rec("t2_empty", 0, 1, 1, 0);
    expect_none("t2_extra");

    // All zeros with consumer stalled: fills after four pushes.
    out_ready = 1'b0;
    load(8'h00);
    check("t3_ready_start", in_ready, 1);
    repeat (3) @(negedge clk);
    check("t3_ready_3push", in_ready, 1);
    @(negedge clk);
    check("t3_ready_full", in_ready, 0);
    check("t3_valid_full", out_valid, 1);
    check("t3_head_index", out_index, 0);
    repeat (3) @(negedge clk);
    check("t3_ready_hold", in_ready, 0);
    expect_none("t3_no_accept");
    out_ready = 1'b1;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++)
      expect_rec($sformatf("t3_r%0d", i), i, (i == 7), 0, (i == 7) ? 8 : 0);
    expect_none("t3_extra");

    // Single zero at bit 0: push-to-valid latency of one cycle.
    load(8'hFE);
    check("t4_presented", in_valid, 1);
    check("t4_lat0", out_valid, 0);
    @(negedge clk);
    check("t4_lat1", out_valid, 1);
    check("t4_index", out_index, 0);
    check("t4_last", out_last, 1);
    check("t4_empty", out_empty, 0);
    check("t4_count", out_count, 1);
    repeat (4) @(negedge clk);
    expect_rec("t4_rec", 0, 1, 0, 1);
    expect_none("t4_extra");

    // Reload mid-batch; the load-cycle response (index 2) is dropped.
    load(8'hF0);
    repeat (2) @(negedge clk);
    check("t5_loadcyc_valid", in_valid, 1);
    check("t5_loadcyc_index", in_index, 2);
    load(8'hF0);
    repeat (10) @(negedge clk);
    expect_rec("t5_r0", 0, 0, 0, 0);
    expect_rec("t5_r1", 1, 0, 0, 0);
    expect_rec("t5_r2", 0, 0, 0, 0);
    expect_rec("t5_r3", 1, 0, 0, 0);
    expect_rec("t5_r4", 2, 0, 0, 0);
    expect_rec("t5_r5", 3, 1, 0, 4);
    expect_none("t5_extra");

    // Reset with three records queued discards them.
    out_ready = 1'b0;
    load(8'hF0);
    repeat (3) @(negedge clk);
    check("t6_queued", out_valid, 1);
    check("t6_queued_ready", in_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    load(8'hFD);
    repeat (6) @(negedge clk);
    expect_rec("t6_rec", 1, 1, 0, 1);
    expect_none("t6_extra");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
